byte_mux_2_to_1: RTL and testbench

BYTE_MUX_2_TO_1 -- requirements
Module: byte_mux_2_to_1

---
 rtl/byte_mux_2_to_1_if.sv | 40 ++++
 rtl/byte_mux_2_to_1.sv | 85 ++++++++
 tb/tb_byte_mux_2_to_1.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/byte_mux_2_to_1_if.sv
// ============================================================================
// byte_mux_2_to_1_if
// ----------------------------------------------------------------------------
// Purpose : Bundles the data, select and status signals of byte_mux_2_to_1.
//           clk and rst are not part of the bundle; they stay plain ports.
// Signals :
//   a, b    - WIDTH-bit data inputs (a chosen when s != 1, b when s == 1)
//   s       - select
//   o       - combinational mux output
//   o_q     - registered copy of o
//   s_q     - registered copy of s
//   sw_cnt  - CNT_W-bit saturating count of select changes
//   o_par   - even-parity bit of o_q (constant 0 unless parity is enabled)
// Modports:
//   master  - stimulus side: drives a/b/s, observes everything else
//   slave   - mux side: consumes a/b/s, drives the outputs
// ============================================================================
interface byte_mux_2_to_1_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] o_q;
    logic             s_q;
    logic [CNT_W-1:0] sw_cnt;
    logic             o_par;

    modport master (
        output a, b, s,
        input  o, o_q, s_q, sw_cnt, o_par
    );

    modport slave (
        input  a, b, s,
        output o, o_q, s_q, sw_cnt, o_par
    );
endinterface

// File: rtl/byte_mux_2_to_1.sv
// ============================================================================
// byte_mux_2_to_1
// ----------------------------------------------------------------------------
// Purpose : 2:1 data mux with a registered copy of its output and select,
//           a saturating counter of select changes, and an optional
//           registered even-parity bit.
// Ports   :
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset (does not affect the mux output)
//   bus  - byte_mux_2_to_1_if.slave (a, b, s in; o, o_q, s_q, sw_cnt, o_par out)
// Config  :
//   BYTE_MUX_PARITY_EN defined   -> o_par is registered ^(value loaded into o_q)
//   BYTE_MUX_PARITY_EN undefined -> o_par tied to 0, no parity logic built
// ============================================================================
module byte_mux_2_to_1 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    byte_mux_2_to_1_if.slave      bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] w_o;
    logic             w_sw_change;
    logic [WIDTH-1:0] r_o_q;
    logic             r_s_q;
    logic [CNT_W-1:0] r_sw_cnt;

    // NOTE: always_comb with a full if/else so every path assigns w_o; a
    // missing else here would infer a latch.
    // An if on an X/Z select falls to the else branch, so anything but a
    // clean 1 picks a.
    always_comb begin
        if (bus.s == 1'b1) begin
            w_o = bus.b;
        end else begin
            w_o = bus.a;
        end
    end

    assign w_sw_change = (bus.s != r_s_q);

    // NOTE: registered state uses non-blocking assignments so all registers
    // sample the pre-edge values of each other, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_q    <= '0;
            r_s_q    <= 1'b0;
            r_sw_cnt <= '0;
        end else begin
            r_o_q <= w_o;
            r_s_q <= bus.s;
            // Hold at all-ones rather than wrapping back to 0.
            if (w_sw_change && (r_sw_cnt != CNT_MAX)) begin
                r_sw_cnt <= r_sw_cnt + 1'b1;
            end
        end
    end

`ifdef BYTE_MUX_PARITY_EN
    logic r_o_par;

    // Computed from the mux output being captured, so it lines up with o_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_par <= 1'b0;
        end else begin
            r_o_par <= ^w_o;
        end
    end

    assign bus.o_par = r_o_par;
`else
    assign bus.o_par = 1'b0;
`endif

    assign bus.o      = w_o;
    assign bus.o_q    = r_o_q;
    assign bus.s_q    = r_s_q;
    assign bus.sw_cnt = r_sw_cnt;

endmodule

// File: tb/tb_byte_mux_2_to_1.sv
// ============================================================================
// tb_byte_mux_2_to_1
// ----------------------------------------------------------------------------
// Self-checking bench for byte_mux_2_to_1: a table of combinational mux
// vectors, hand-written register-path / parity / saturation / mid-run reset
// sequences, and a randomized run compared against a behavioural model.
// ============================================================================
module tb_byte_mux_2_to_1;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    byte_mux_2_to_1_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    byte_mux_2_to_1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state: what the registered outputs should be now.
    int m_oq;
    int m_sq;
    int m_cnt;
    int m_par;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] exp_o;
    } mux_vec_t;

    mux_vec_t vecs [5];

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int parity_of(input int v);
        int p;
        p = 0;
        for (int i = 0; i < WIDTH; i++) p ^= (v >> i) & 1;
        return p;
    endfunction

    function automatic int exp_par(input int oq);
`ifdef BYTE_MUX_PARITY_EN
        return parity_of(oq);
`else
        return 0;
`endif
    endfunction

    // Mux rule straight from the function: b on a clean 1, a otherwise.
    function automatic int ref_mux(input int a, input int b, input logic s);
        return (s === 1'b1) ? b : a;
    endfunction

    task automatic drive(input int a, input int b, input logic s);
        bus.a = a[7:0];
        bus.b = b[7:0];
        bus.s = s;
    endtask

    // One clock edge: advance the model from the inputs present at the edge,
    // then compare every registered output shortly after the edge.
    task automatic tick(input logic rst_v, input string tag);
        int cur_o;
        int cur_s;
        rst   = rst_v;
        cur_o = ref_mux(int'(bus.a), int'(bus.b), bus.s);
        cur_s = (bus.s === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        if (rst_v) begin
            m_oq  = 0;
            m_sq  = 0;
            m_cnt = 0;
            m_par = 0;
        end else begin
            if (cur_s != m_sq && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            m_oq  = cur_o;
            m_sq  = cur_s;
            m_par = exp_par(cur_o);
        end
        check({tag, " o_q"},    int'(bus.o_q),    m_oq);
        check({tag, " s_q"},    int'(bus.s_q),    m_sq);
        check({tag, " sw_cnt"}, int'(bus.sw_cnt), m_cnt);
        check({tag, " o_par"},  int'(bus.o_par),  m_par);
        check({tag, " o"},      int'(bus.o),      ref_mux(int'(bus.a), int'(bus.b), bus.s));
    endtask

    initial begin
        vecs[0] = '{8'h44, 8'h25, 1'b0, 8'h44};
        vecs[1] = '{8'h99, 8'h83, 1'b1, 8'h83};
        vecs[2] = '{8'hE2, 8'h1B, 1'b0, 8'hE2};
        vecs[3] = '{8'h6C, 8'h0F, 1'b1, 8'h0F};
        vecs[4] = '{8'hBC, 8'hC1, 1'b1, 8'hC1};

        m_oq = 0; m_sq = 0; m_cnt = 0; m_par = 0;
        drive(0, 0, 1'b0);

        // Combinational mux table, no clock edge involved.
        for (int i = 0; i < 5; i++) begin
            drive(int'(vecs[i].a), int'(vecs[i].b), vecs[i].s);
            #1;
            check($sformatf("mux_vec%0d", i), int'(bus.o), int'(vecs[i].exp_o));
        end

        // Reset state.
        tick(1'b1, "reset");
        check("reset o_q zero",    int'(bus.o_q),    0);
        check("reset sw_cnt zero", int'(bus.sw_cnt), 0);

        // Register path: s = 0,1,0,1,1, one cycle each.
        begin
            logic s_seq [5];
            s_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            for (int i = 0; i < 5; i++) begin
                drive(8'h10 + i, 8'hA0 + i, s_seq[i]);
                tick(1'b0, $sformatf("seq%0d", i));
            end
            check("seq final sw_cnt", int'(bus.sw_cnt), 3);
            check("seq final o_q",    int'(bus.o_q),    8'hA4);
        end

        // Parity sequence.
        tick(1'b1, "par_rst");
        drive(8'h44, 8'h25, 1'b0);
        tick(1'b0, "par44");
        check("par o_q=0x44", int'(bus.o_par), 0);
        drive(8'h99, 8'h83, 1'b1);
        tick(1'b0, "par83");
`ifdef BYTE_MUX_PARITY_EN
        check("par o_q=0x83", int'(bus.o_par), 1);
`else
        check("par o_q=0x83", int'(bus.o_par), 0);
`endif

        // Saturation: 300 toggles from a clean reset.
        tick(1'b1, "sat_rst");
        for (int i = 0; i < 300; i++) begin
            drive(i & 8'hFF, (i * 7) & 8'hFF, ((i & 1) == 0) ? 1'b1 : 1'b0);
            tick(1'b0, "sat");
        end
        check("sat sw_cnt=255", int'(bus.sw_cnt), 255);

        // Mid-run reset with s=1 held.
        drive(8'hBC, 8'hC1, 1'b1);
        tick(1'b0, "mid_pre");
        tick(1'b1, "mid_rst");
        check("mid_rst o_q",    int'(bus.o_q),    0);
        check("mid_rst s_q",    int'(bus.s_q),    0);
        check("mid_rst sw_cnt", int'(bus.sw_cnt), 0);
        check("mid_rst o",      int'(bus.o),      8'hC1);
        tick(1'b0, "mid_post");
        check("mid_post o_q",    int'(bus.o_q),    8'hC1);
        check("mid_post sw_cnt", int'(bus.sw_cnt), 1);

        // Randomized run against the model, including occasional resets and
        // data-only changes with s held.
        for (int i = 0; i < 400; i++) begin
            logic s_r;
            s_r = ($urandom_range(0, 3) == 0) ? ~bus.s : bus.s;
            drive($urandom_range(0, 255), $urandom_range(0, 255), s_r);
            #1;
            check("rnd o comb", int'(bus.o), ref_mux(int'(bus.a), int'(bus.b), bus.s));
            tick(($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
